// File: rtl/pwm_shift_scheduler_if.sv
// Config write port and shift-register drive signals of the PWM scheduler.
interface pwm_shift_scheduler_if #(
   parameter int unsigned NCH = 8,
   parameter int unsigned DW  = 8
);
   localparam int unsigned AW = (NCH > 1) ? $clog2(NCH) : 1;

   logic          enable;
   logic          cfg_we;
   logic [AW-1:0] cfg_addr;
   logic [DW-1:0] cfg_duty;
   logic          cfg_commit;
   logic          sr_data;
   logic          sr_shift;
   logic          sr_latch;
   logic          sr_clear;
   logic [DW-1:0] step;
   logic          period_start;
   logic          busy;

   modport master (
      output enable, cfg_we, cfg_addr, cfg_duty, cfg_commit,
      input  sr_data, sr_shift, sr_latch, sr_clear, step, period_start, busy
   );

   modport slave (
      input  enable, cfg_we, cfg_addr, cfg_duty, cfg_commit,
      output sr_data, sr_shift, sr_latch, sr_clear, step, period_start, busy
   );
endinterface

// File: rtl/pwm_shift_scheduler.sv
// Per-step serial frame sequencer for an NCH-deep PWM shift register with
// double-buffered duty configuration applied at period boundaries.
module pwm_shift_scheduler #(
   parameter int unsigned NCH      = 8,
   parameter int unsigned PERIOD   = 100,
   parameter int unsigned DW       = 8,
   parameter int unsigned PRESCALE = 16
) (
   input logic clk,
   input logic reset_n,
   pwm_shift_scheduler_if.slave bus
);
   localparam int unsigned AW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   typedef enum logic [2:0] {CLR, CLRLATCH, IDLE, SHIFT, LATCH} state_t;

   state_t        state, state_next;
   logic          in_reset;
   logic [PW-1:0] prescaler;
   logic [AW-1:0] bit_cnt;
   logic [AW-1:0] idx;
   logic [DW-1:0] step_q;
   logic [DW-1:0] shadow      [NCH];
   logic [DW-1:0] shadow_next [NCH];
   logic [DW-1:0] active      [NCH];
   logic          commit_pending;
   logic          tick;
   logic          do_commit;

   assign tick      = (state == IDLE) && bus.enable && (prescaler == PW'(PRESCALE - 1));
   assign do_commit = tick && (step_q == '0) && (commit_pending || bus.cfg_commit);
   assign idx       = AW'(NCH - 1) - bit_cnt;

   // A write landing in the commit cycle must reach the active copy.
   always_comb begin
      for (int unsigned i = 0; i < NCH; i++) begin
         shadow_next[i] = shadow[i];
         if (bus.cfg_we && (bus.cfg_addr == AW'(i))) shadow_next[i] = bus.cfg_duty;
      end
   end

   always_comb begin
      state_next       = state;
      bus.sr_clear     = 1'b0;
      bus.sr_latch     = 1'b0;
      bus.sr_shift     = 1'b0;
      bus.sr_data      = 1'b0;
      bus.period_start = 1'b0;
      bus.busy         = 1'b0;
      case (state)
         CLR:      state_next = CLRLATCH;
         CLRLATCH: state_next = IDLE;
         IDLE:     if (tick) state_next = SHIFT;
         SHIFT:    if (bit_cnt == AW'(NCH - 1)) state_next = LATCH;
         LATCH:    state_next = IDLE;
         default:  state_next = CLR;
      endcase
      // Outputs stay quiet for as long as reset is held.
      if (!in_reset) begin
         bus.busy = (state != IDLE);
         case (state)
            CLR:      bus.sr_clear = 1'b1;
            CLRLATCH: bus.sr_latch = 1'b1;
            SHIFT: begin
               bus.sr_shift = 1'b1;
               bus.sr_data  = (step_q < active[idx]);
            end
            LATCH: begin
               bus.sr_latch     = 1'b1;
               bus.period_start = (step_q == '0);
            end
            default: ;
         endcase
      end
   end

   assign bus.step = step_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         in_reset       <= 1'b1;
         state          <= CLR;
         prescaler      <= '0;
         bit_cnt        <= '0;
         step_q         <= '0;
         commit_pending <= 1'b0;
         for (int unsigned i = 0; i < NCH; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         in_reset <= 1'b0;
         // CLR is held one extra cycle so the clear pulse is visible after release.
         if (!in_reset) state <= state_next;

         for (int unsigned i = 0; i < NCH; i++) begin
            shadow[i] <= shadow_next[i];
            if (do_commit) active[i] <= shadow_next[i];
         end
         if (do_commit)           commit_pending <= 1'b0;
         else if (bus.cfg_commit) commit_pending <= 1'b1;

         if ((state == IDLE) && !bus.enable)
            prescaler <= '0;
         else if ((state == IDLE) || (state == SHIFT) || (state == LATCH))
            prescaler <= (prescaler == PW'(PRESCALE - 1)) ? '0 : prescaler + 1'b1;

         if ((state == SHIFT) && (bit_cnt != AW'(NCH - 1))) bit_cnt <= bit_cnt + 1'b1;
         else                                               bit_cnt <= '0;

         if (state == LATCH)
            step_q <= (step_q == DW'(PERIOD - 1)) ? '0 : step_q + 1'b1;
      end
   end
endmodule

// File: tb/tb_pwm_shift_scheduler.sv
// Randomized self-checking bench for pwm_shift_scheduler against a frame-level model.
module tb_pwm_shift_scheduler;
   localparam int NCH = 8, PERIOD = 100, DW = 8, PRESCALE = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   int m_shadow [NCH];
   int m_active [NCH];
   bit m_pending = 1'b0;
   int m_step = 0;

   pwm_shift_scheduler_if #(.NCH(NCH), .DW(DW)) bus();

   pwm_shift_scheduler #(.NCH(NCH), .PERIOD(PERIOD), .DW(DW), .PRESCALE(PRESCALE)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic cfg_write(input int addr, input int duty, input bit commit);
      bus.cfg_we = 1'b1; bus.cfg_addr = 3'(addr); bus.cfg_duty = 8'(duty); bus.cfg_commit = commit;
      @(negedge clk);
      bus.cfg_we = 1'b0; bus.cfg_commit = 1'b0;
      m_shadow[addr] = duty;
      if (commit) m_pending = 1'b1;
   endtask

   // Collects one frame (waits for the first shift bit); bits[ch] holds channel ch.
   task automatic capture_frame(output logic [NCH-1:0] bits, output logic [DW-1:0] st,
                                output logic ps, output bit ok, output int lat_cyc);
      int n = 0;
      ok = 1'b1; bits = '0; st = '0; ps = 1'b0; lat_cyc = 0;
      while (bus.sr_shift !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) begin ok = 1'b0; return; end
      st = bus.step;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (bus.sr_shift !== 1'b1) ok = 1'b0;
         bits[i] = bus.sr_data;
         @(negedge clk);
      end
      if (bus.sr_latch !== 1'b1 || bus.sr_shift !== 1'b0) ok = 1'b0;
      ps = bus.period_start;
      lat_cyc = cyc;
      @(negedge clk);
   endtask

   // Frame expected at the model's current step, then advance the step.
   task automatic model_frame(output logic [NCH-1:0] exp, output int st, output bit ps);
      if (m_step == 0 && m_pending) begin
         m_active = m_shadow;
         m_pending = 1'b0;
      end
      for (int ch = 0; ch < NCH; ch++) exp[ch] = (m_step < m_active[ch]);
      st = m_step;
      ps = (m_step == 0);
      m_step = (m_step + 1) % PERIOD;
   endtask

   task automatic test_reset;
      logic [DW+5:0] outs;
      bus.enable = 1'b0; bus.cfg_we = 1'b0; bus.cfg_commit = 1'b0;
      bus.cfg_addr = '0; bus.cfg_duty = '0;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      outs = {bus.sr_data, bus.sr_shift, bus.sr_latch, bus.sr_clear, bus.period_start, bus.busy, bus.step};
      checks++;
      if (outs !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", outs); end
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.sr_clear, bus.sr_latch, bus.busy} !== 3'b101) begin
         failures++; $display("FAIL reset_clear_pulse got=%b exp=101", {bus.sr_clear, bus.sr_latch, bus.busy});
      end
      @(negedge clk);
      checks++;
      if ({bus.sr_clear, bus.sr_latch, bus.busy} !== 3'b011) begin
         failures++; $display("FAIL reset_latch_pulse got=%b exp=011", {bus.sr_clear, bus.sr_latch, bus.busy});
      end
      @(negedge clk);
      checks++;
      if ({bus.sr_clear, bus.sr_latch, bus.sr_shift, bus.busy, bus.step} !== '0) begin
         failures++; $display("FAIL reset_idle got=%b step=%0d exp=idle step 0",
                              {bus.sr_clear, bus.sr_latch, bus.sr_shift, bus.busy}, bus.step);
      end
   endtask

   task automatic test_duty_frames;
      logic [NCH-1:0] got, exp;
      logic [DW-1:0] st;
      logic ps;
      bit ok, eps;
      int est, lc, prev;
      for (int i = 0; i < NCH; i++) cfg_write(i, 10 * (i + 1), 1'b0);
      cfg_write(0, 10, 1'b1);
      bus.enable = 1'b1;
      prev = -1;
      for (int f = 0; f < 16; f++) begin
         capture_frame(got, st, ps, ok, lc);
         model_frame(exp, est, eps);
         checks++;
         if (!ok || got !== exp || st !== 8'(est) || ps !== eps) begin
            failures++;
            $display("FAIL duty_frame step=%0d ok=%0d got=%b exp=%b step_got=%0d ps=%b exp_ps=%b",
                     est, ok, got, exp, st, ps, eps);
         end
         if (prev >= 0) begin
            checks++;
            if (lc - prev !== PRESCALE) begin
               failures++; $display("FAIL step_interval got=%0d exp=%0d", lc - prev, PRESCALE);
            end
         end
         prev = lc;
         if (est == 15) begin
            checks++;
            if (got !== 8'hFE) begin failures++; $display("FAIL step15_pattern got=%b exp=11111110", got); end
         end
      end
   endtask

   task automatic test_commit_boundary;
      logic [NCH-1:0] got, exp;
      logic [DW-1:0] st;
      logic ps;
      bit ok, eps;
      int est, lc;
      est = -1;
      for (int f = 0; f < 100 && est != 50; f++) begin
         capture_frame(got, st, ps, ok, lc);
         model_frame(exp, est, eps);
         checks++;
         if (!ok || got !== exp || st !== 8'(est)) begin
            failures++; $display("FAIL pre_commit_frame step=%0d got=%b exp=%b", est, got, exp);
         end
      end
      cfg_write(7, 0, 1'b1);
      cfg_write(3, int'($urandom_range(0, 255)), 1'b0);
      for (int f = 0; f < 52; f++) begin
         capture_frame(got, st, ps, ok, lc);
         model_frame(exp, est, eps);
         checks++;
         if (!ok || got !== exp || st !== 8'(est) || ps !== eps) begin
            failures++; $display("FAIL commit_frame step=%0d got=%b exp=%b step_got=%0d", est, got, exp, st);
         end
         if (est == 51) begin
            checks++;
            if (got[7] !== 1'b1) begin failures++; $display("FAIL ch7_before_boundary got=%b exp=1", got[7]); end
         end
         if (est == 0) begin
            checks++;
            if (got[7] !== 1'b0) begin failures++; $display("FAIL ch7_after_boundary got=%b exp=0", got[7]); end
         end
      end
   endtask

   task automatic test_extreme_duties;
      logic [NCH-1:0] got, exp;
      logic [DW-1:0] st;
      logic ps;
      bit ok, eps, applied;
      int est, lc;
      cfg_write(0, 0, 1'b0);
      cfg_write(1, 100, 1'b0);
      cfg_write(2, 255, 1'b0);
      cfg_write(4, int'($urandom_range(0, 255)), 1'b1);
      applied = 1'b0;
      for (int f = 0; f < 400; f++) begin
         capture_frame(got, st, ps, ok, lc);
         model_frame(exp, est, eps);
         checks++;
         if (!ok || got !== exp || st !== 8'(est) || ps !== eps) begin
            failures++; $display("FAIL extreme_frame step=%0d got=%b exp=%b", est, got, exp);
         end
         if (est == 0) applied = 1'b1;
         if (applied && (est == 0 || est == 99)) begin
            checks++;
            if (got[2:0] !== 3'b110) begin
               failures++; $display("FAIL extreme_bits step=%0d got=%b exp=110", est, got[2:0]);
            end
         end
         if (applied && est == 99) break;
         if (m_step > 10 && m_step < 90)
            cfg_write(int'($urandom_range(3, 7)), int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end
      checks++;
      if (!(applied && m_step == 0)) begin
         failures++; $display("FAIL extreme_coverage got=step %0d exp=wrapped to 0", m_step);
      end
   endtask

   task automatic test_free_run;
      logic [NCH-1:0] got, exp;
      logic [DW-1:0] st;
      logic ps;
      bit ok, eps;
      int est, lc, pulses, first;
      pulses = 0; first = 0;
      for (int f = 0; f < 250 && pulses < 2; f++) begin
         capture_frame(got, st, ps, ok, lc);
         model_frame(exp, est, eps);
         checks++;
         if (!ok || got !== exp || st !== 8'(est) || ps !== eps) begin
            failures++; $display("FAIL free_frame step=%0d got=%b exp=%b ps=%b exp_ps=%b", est, got, exp, ps, eps);
         end
         if (ps === 1'b1) begin
            if (pulses == 1) begin
               checks++;
               if (lc - first !== PERIOD * PRESCALE) begin
                  failures++; $display("FAIL period_interval got=%0d exp=%0d", lc - first, PERIOD * PRESCALE);
               end
            end
            first = lc;
            pulses++;
         end
      end
      checks++;
      if (pulses != 2) begin failures++; $display("FAIL period_pulses got=%0d exp=2", pulses); end
   endtask

   task automatic test_enable_pause;
      logic [NCH-1:0] got, exp;
      logic [DW-1:0] st;
      logic ps;
      bit ok, eps, stray;
      int est, lc, n;
      n = 0;
      while (bus.sr_shift !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      for (int i = NCH - 1; i >= 0; i--) begin
         got[i] = bus.sr_data;
         if (i == NCH - 3) bus.enable = 1'b0;
         @(negedge clk);
      end
      model_frame(exp, est, eps);
      checks++;
      if (bus.sr_latch !== 1'b1 || got !== exp) begin
         failures++; $display("FAIL paused_frame latch=%b got=%b exp=%b", bus.sr_latch, got, exp);
      end
      stray = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.sr_shift !== 1'b0 || bus.busy !== 1'b0 || bus.step !== 8'(m_step)) stray = 1'b1;
      end
      checks++;
      if (stray) begin failures++; $display("FAIL pause_hold got=step %0d exp=step %0d idle", bus.step, m_step); end
      bus.enable = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (bus.sr_shift !== 1'b1 && n < 100);
      checks++;
      if (n != PRESCALE) begin failures++; $display("FAIL resume_delay got=%0d exp=%0d", n, PRESCALE); end
      capture_frame(got, st, ps, ok, lc);
      model_frame(exp, est, eps);
      checks++;
      if (!ok || got !== exp || st !== 8'(est)) begin
         failures++; $display("FAIL resume_frame step_got=%0d exp=%0d got=%b exp=%b", st, est, got, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < NCH; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
      test_reset();
      test_duty_frames();
      test_commit_boundary();
      test_extreme_duties();
      test_free_run();
      test_enable_pause();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
